input_cache_ctrl: RTL and testbench

Sequencer for the input activation cache: a TPU-side `A x N` array of 32-bit words with one-cycle registered row read and single-word write. It streams activation words from a valid/ready source into the cache in row-major order (load phase). On command it then reads rows back one per cycle into the systolic array feed, honouring consumer stall (run phase). It owns every cache control pin, so no other requester drives the cache.

---
 rtl/input_cache_ctrl_if.sv | 33 +++
 rtl/input_cache_ctrl.sv | 161 ++++++++++++++++
 tb/tb_input_cache_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_cache_ctrl_if.sv
// rtl/input_cache_ctrl_if.sv - command, stream, cache-pin and status bundle for input_cache_ctrl
interface input_cache_ctrl_if;
  logic [15:0] cfg_rows;
  logic        load_start;
  logic        run_start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        stall;
  logic        mem_enable;
  logic        wr_rd;
  logic [31:0] data_in;
  logic [15:0] sel_a;
  logic [7:0]  sel_n;
  logic        row_valid;
  logic [15:0] row_idx;
  logic        busy;
  logic        load_done;
  logic        run_done;
  logic        cfg_err;

  modport master (
    input  cfg_rows, load_start, run_start, s_data, s_valid, stall,
    output s_ready, mem_enable, wr_rd, data_in, sel_a, sel_n,
           row_valid, row_idx, busy, load_done, run_done, cfg_err
  );

  modport slave (
    output cfg_rows, load_start, run_start, s_data, s_valid, stall,
    input  s_ready, mem_enable, wr_rd, data_in, sel_a, sel_n,
           row_valid, row_idx, busy, load_done, run_done, cfg_err
  );
endinterface

// File: rtl/input_cache_ctrl.sv
// rtl/input_cache_ctrl.sv - load/run sequencer owning all input activation cache pins
module input_cache_ctrl #(
  parameter int A = 60000,
  parameter int N = 256
) (
  input logic                 clk,
  input logic                 rst,
  input_cache_ctrl_if.master  bus_io
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  localparam logic [16:0] A_MAX  = 17'(A);
  localparam logic [7:0]  N_LAST = 8'(N - 1);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  n_q, n_d;
  logic [15:0] rows_q, rows_d;
  logic        row_valid_q, row_valid_d;
  logic [15:0] row_idx_q, row_idx_d;
  logic        load_done_q, load_done_d;
  logic        run_done_q, run_done_d;
  logic        cfg_err_q, cfg_err_d;

  logic        cfg_ok;
  logic        s_ready;
  logic        mem_enable;
  logic        wr_rd;
  logic [31:0] data_in;
  logic [15:0] sel_a;
  logic [7:0]  sel_n;

  assign cfg_ok = (bus_io.cfg_rows != 16'd0) && ({1'b0, bus_io.cfg_rows} <= A_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      n_q         <= '0;
      rows_q      <= '0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      load_done_q <= 1'b0;
      run_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      n_q         <= n_d;
      rows_q      <= rows_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      load_done_q <= load_done_d;
      run_done_q  <= run_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    n_d         = n_q;
    rows_d      = rows_q;
    row_valid_d = 1'b0;
    row_idx_d   = row_idx_q;
    load_done_d = 1'b0;
    run_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    s_ready     = 1'b0;
    mem_enable  = 1'b0;
    wr_rd       = 1'b0;
    data_in     = '0;
    sel_a       = '0;
    sel_n       = '0;

    unique case (state_q)
      IDLE: begin
        // load_start has priority; a simultaneous run_start is simply dropped
        if (bus_io.load_start) begin
          if (cfg_ok) begin
            state_d = LOAD;
            rows_d  = bus_io.cfg_rows;
            a_d     = '0;
            n_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (bus_io.run_start) begin
          if (cfg_ok) begin
            state_d = RUN;
            rows_d  = bus_io.cfg_rows;
            a_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        s_ready    = 1'b1;
        mem_enable = bus_io.s_valid;
        wr_rd      = 1'b1;
        data_in    = bus_io.s_data;
        sel_a      = a_q;
        sel_n      = n_q;
        if (bus_io.s_valid) begin
          if (n_q == N_LAST) begin
            n_d = '0;
            if (a_q == rows_q - 16'd1) begin
              a_d         = '0;
              state_d     = IDLE;
              load_done_d = 1'b1;
            end else begin
              a_d = a_q + 16'd1;
            end
          end else begin
            n_d = n_q + 8'd1;
          end
        end
      end

      RUN: begin
        mem_enable = !bus_io.stall;
        sel_a      = a_q;
        if (!bus_io.stall) begin
          row_valid_d = 1'b1;
          row_idx_d   = a_q;
          // run_done lands in FLUSH, together with the last row's row_valid
          if (a_q == rows_q - 16'd1) begin
            a_d        = '0;
            state_d    = FLUSH;
            run_done_d = 1'b1;
          end else begin
            a_d = a_q + 16'd1;
          end
        end
      end

      FLUSH: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus_io.s_ready    = s_ready;
  assign bus_io.mem_enable = mem_enable;
  assign bus_io.wr_rd      = wr_rd;
  assign bus_io.data_in    = data_in;
  assign bus_io.sel_a      = sel_a;
  assign bus_io.sel_n      = sel_n;
  assign bus_io.row_valid  = row_valid_q;
  assign bus_io.row_idx    = row_idx_q;
  assign bus_io.busy       = (state_q != IDLE);
  assign bus_io.load_done  = load_done_q;
  assign bus_io.run_done   = run_done_q;
  assign bus_io.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_input_cache_ctrl.sv
// tb/tb_input_cache_ctrl.sv - table-driven bench for input_cache_ctrl with A=4, N=4
module tb_input_cache_ctrl;

  logic clk;
  logic rst;
  input_cache_ctrl_if bus();

  input_cache_ctrl #(.A(4), .N(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ls, rs;
    logic [15:0] cfg;
    logic        sv;
    logic [31:0] sd;
    logic        st;
    logic        e_srdy, e_me, e_wr;
    logic [31:0] e_din;
    logic [15:0] e_sa;
    logic [7:0]  e_sn;
    logic        e_rv;
    logic [15:0] e_ri;
    logic        e_busy, e_ld, e_rd, e_ce;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t f_idle(logic ls, logic rs, logic [15:0] cfg, logic ld, logic rd, logic ce);
    vec_t v;
    v = '{ls:ls, rs:rs, cfg:cfg, sv:1'b0, sd:32'h0, st:1'b0,
          e_srdy:1'b0, e_me:1'b0, e_wr:1'b0, e_din:32'h0, e_sa:16'h0, e_sn:8'h0,
          e_rv:1'b0, e_ri:16'h0, e_busy:1'b0, e_ld:ld, e_rd:rd, e_ce:ce};
    return v;
  endfunction

  function automatic vec_t f_load(logic ls, logic sv, logic [31:0] sd, int a, int n);
    vec_t v;
    v = '{ls:ls, rs:1'b0, cfg:16'h0, sv:sv, sd:sd, st:1'b0,
          e_srdy:1'b1, e_me:sv, e_wr:1'b1, e_din:sd, e_sa:16'(a), e_sn:8'(n),
          e_rv:1'b0, e_ri:16'h0, e_busy:1'b1, e_ld:1'b0, e_rd:1'b0, e_ce:1'b0};
    return v;
  endfunction

  function automatic vec_t f_run(logic st, int a, logic rv, int ri);
    vec_t v;
    v = '{ls:1'b0, rs:1'b0, cfg:16'h0, sv:1'b0, sd:32'h0, st:st,
          e_srdy:1'b0, e_me:!st, e_wr:1'b0, e_din:32'h0, e_sa:16'(a), e_sn:8'h0,
          e_rv:rv, e_ri:16'(ri), e_busy:1'b1, e_ld:1'b0, e_rd:1'b0, e_ce:1'b0};
    return v;
  endfunction

  function automatic vec_t f_flush(int ri);
    vec_t v;
    v = '{ls:1'b0, rs:1'b0, cfg:16'h0, sv:1'b0, sd:32'h0, st:1'b0,
          e_srdy:1'b0, e_me:1'b0, e_wr:1'b0, e_din:32'h0, e_sa:16'h0, e_sn:8'h0,
          e_rv:1'b1, e_ri:16'(ri), e_busy:1'b1, e_ld:1'b0, e_rd:1'b1, e_ce:1'b0};
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic ls, logic rs, logic [15:0] cfg, logic sv, logic [31:0] sd, logic st);
    bus.load_start = ls;
    bus.run_start  = rs;
    bus.cfg_rows   = cfg;
    bus.s_valid    = sv;
    bus.s_data     = sd;
    bus.stall      = st;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 32'h0, 0);

    // 1: continuous load of 2 rows
    vq.push_back(f_idle(1, 0, 16'd2, 0, 0, 0));
    for (int i = 0; i < 8; i++) vq.push_back(f_load(0, 1, 32'h10 + 32'(i), i / 4, i % 4));
    vq.push_back(f_idle(0, 0, 16'd0, 1, 0, 0));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 0));
    // 2: same load with s_valid low on every other cycle
    vq.push_back(f_idle(1, 0, 16'd2, 0, 0, 0));
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 1) vq.push_back(f_load(0, 1, 32'h20 + 32'((k - 1) / 2), ((k - 1) / 2) / 4, ((k - 1) / 2) % 4));
      else            vq.push_back(f_load(0, 0, 32'h0, (k / 2) / 4, (k / 2) % 4));
    end
    vq.push_back(f_idle(0, 0, 16'd0, 1, 0, 0));
    // 3: run 3 rows, no stall
    vq.push_back(f_idle(0, 1, 16'd3, 0, 0, 0));
    vq.push_back(f_run(0, 0, 0, 0));
    vq.push_back(f_run(0, 1, 1, 0));
    vq.push_back(f_run(0, 2, 1, 1));
    vq.push_back(f_flush(2));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 0));
    // 4: run 3 rows, stall on second run cycle
    vq.push_back(f_idle(0, 1, 16'd3, 0, 0, 0));
    vq.push_back(f_run(0, 0, 0, 0));
    vq.push_back(f_run(1, 1, 1, 0));
    vq.push_back(f_run(0, 1, 0, 0));
    vq.push_back(f_run(0, 2, 1, 1));
    vq.push_back(f_flush(2));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 0));
    // 5: bad cfg_rows (0 and A+1) on both start commands
    vq.push_back(f_idle(1, 0, 16'd0, 0, 0, 0));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 1));
    vq.push_back(f_idle(1, 0, 16'd5, 0, 0, 0));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 1));
    vq.push_back(f_idle(0, 1, 16'd5, 0, 0, 0));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 1));
    // 6: both starts together -> load; bad start inside LOAD is ignored
    vq.push_back(f_idle(1, 1, 16'd1, 0, 0, 0));
    vq.push_back(f_load(1, 0, 32'h0, 0, 0));
    for (int i = 0; i < 4; i++) vq.push_back(f_load(0, 1, 32'h30 + 32'(i), 0, i));
    vq.push_back(f_idle(0, 0, 16'd0, 1, 0, 0));
    // 7: run of a single row
    vq.push_back(f_idle(0, 1, 16'd1, 0, 0, 0));
    vq.push_back(f_run(0, 0, 0, 0));
    vq.push_back(f_flush(0));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 0));
    // 8: run of A rows
    vq.push_back(f_idle(0, 1, 16'd4, 0, 0, 0));
    for (int i = 0; i < 4; i++) vq.push_back(f_run(0, i, i > 0, i - 1));
    vq.push_back(f_flush(3));
    vq.push_back(f_idle(0, 0, 16'd0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",      -1, 32'(bus.busy),       32'h0);
    chk("rst_s_ready",   -1, 32'(bus.s_ready),    32'h0);
    chk("rst_mem_en",    -1, 32'(bus.mem_enable), 32'h0);
    chk("rst_row_valid", -1, 32'(bus.row_valid),  32'h0);
    chk("rst_row_idx",   -1, 32'(bus.row_idx),    32'h0);
    chk("rst_flags",     -1, {29'h0, bus.load_done, bus.run_done, bus.cfg_err}, 32'h0);
    next_cycle();

    foreach (vq[i]) begin
      drive(vq[i].ls, vq[i].rs, vq[i].cfg, vq[i].sv, vq[i].sd, vq[i].st);
      @(negedge clk);
      chk("s_ready",    i, 32'(bus.s_ready),    32'(vq[i].e_srdy));
      chk("mem_enable", i, 32'(bus.mem_enable), 32'(vq[i].e_me));
      chk("wr_rd",      i, 32'(bus.wr_rd),      32'(vq[i].e_wr));
      chk("data_in",    i, bus.data_in,         vq[i].e_din);
      chk("sel_a",      i, 32'(bus.sel_a),      32'(vq[i].e_sa));
      chk("sel_n",      i, 32'(bus.sel_n),      32'(vq[i].e_sn));
      chk("row_valid",  i, 32'(bus.row_valid),  32'(vq[i].e_rv));
      if (vq[i].e_rv) chk("row_idx", i, 32'(bus.row_idx), 32'(vq[i].e_ri));
      chk("busy",       i, 32'(bus.busy),       32'(vq[i].e_busy));
      chk("load_done",  i, 32'(bus.load_done),  32'(vq[i].e_ld));
      chk("run_done",   i, 32'(bus.run_done),   32'(vq[i].e_rd));
      chk("cfg_err",    i, 32'(bus.cfg_err),    32'(vq[i].e_ce));
      next_cycle();
    end

    // rst after 3 load handshakes: abort with no load_done
    drive(1, 0, 16'd2, 0, 32'h0, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'd0, 1, 32'h40 + 32'(i), 0);
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",    100, 32'(bus.busy),       32'h0);
    chk("abort_s_ready", 100, 32'(bus.s_ready),    32'h0);
    chk("abort_mem_en",  100, 32'(bus.mem_enable), 32'h0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      chk("abort_no_load_done", 101 + i, 32'(bus.load_done), 32'h0);
    end
    next_cycle();
    drive(1, 0, 16'd1, 0, 32'h0, 0);
    next_cycle();
    drive(0, 0, 16'd0, 1, 32'h50, 0);
    @(negedge clk);
    chk("restart_sel_a",   110, 32'(bus.sel_a),      32'h0);
    chk("restart_sel_n",   110, 32'(bus.sel_n),      32'h0);
    chk("restart_mem_en",  110, 32'(bus.mem_enable), 32'h1);
    chk("restart_data_in", 110, bus.data_in,         32'h50);
    next_cycle();
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 16'd0, 1, 32'h50 + 32'(i), 0);
      @(negedge clk);
      chk("restart_sel_n", 110 + i, 32'(bus.sel_n), 32'(i));
      next_cycle();
    end
    drive(0, 0, 16'd0, 0, 32'h0, 0);
    @(negedge clk);
    chk("restart_load_done", 114, 32'(bus.load_done), 32'h1);
    next_cycle();

    // rst right after a run issue cancels the pending row_valid
    drive(0, 1, 16'd3, 0, 32'h0, 0);
    next_cycle();
    drive(0, 0, 16'd0, 0, 32'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("cancel_issue", 120, 32'(bus.mem_enable), 32'h1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("cancel_row_valid", 121, 32'(bus.row_valid), 32'h0);
    chk("cancel_busy",      121, 32'(bus.busy),      32'h0);
    next_cycle();
    @(negedge clk);
    chk("cancel_run_done",  122, 32'(bus.run_done),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
